// File: rtl/i2c_slave.sv
// I2C slave with a 16 x 8-bit register file and an auto-incrementing pointer.
// The first byte written after the address loads the pointer; later writes go
// to reg[pointer]. Reads return reg[pointer]. The pointer wraps 15 -> 0.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h7E
) (
    input  logic clock,
    input  logic reset_n,
    input  logic scl,
    inout  wire  sda
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic       scl_rise, scl_fall, scl_high;
    logic       start_cond, stop_cond;
    logic [7:0] rx_byte;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [6:0] tx;
    logic       rw;
    logic       first_byte;
    logic       master_ack;
    logic       drive_low;
    logic [3:0] pointer;
    logic [7:0] regs [16];

    // Two-flop synchronizers on scl/sda plus a third flop for edge detection
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
            sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl;    scl_p1 <= scl_p0; scl_p2 <= scl_p1;
            sda_p0 <= sda;    sda_p1 <= sda_p0; sda_p2 <= sda_p1;
        end
    end

    assign scl_rise   = scl_p1 & ~scl_p2;
    assign scl_fall   = ~scl_p1 & scl_p2;
    assign scl_high   = scl_p1 & scl_p2;
    assign start_cond = scl_high & ~sda_p1 & sda_p2;
    assign stop_cond  = scl_high & sda_p1 & ~sda_p2;
    assign rx_byte    = {shift, sda_p1};

    // Open-drain output: only ever pull low or release
    assign sda = drive_low ? 1'b0 : 1'bz;

    // Protocol state machine with register file and pointer
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            tx         <= 7'd0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            master_ack <= 1'b0;
            drive_low  <= 1'b0;
            pointer    <= 4'd0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else if (start_cond) begin
            // START or repeated START aborts any byte in progress
            state      <= ADDR;
            bit_cnt    <= 3'd0;
            master_ack <= 1'b0;
            drive_low  <= 1'b0;
        end else if (stop_cond) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            master_ack <= 1'b0;
            drive_low  <= 1'b0;
        end else begin
            case (state)
                IDLE, IGNORE: begin
                    drive_low <= 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state      <= ADDR_ACK;
                                rw         <= rx_byte[0];
                                first_byte <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    // First falling edge starts the ACK, the second one ends it
                    if (scl_fall) begin
                        if (!drive_low) begin
                            drive_low <= 1'b1;
                        end else if (rw) begin
                            tx        <= regs[pointer][6:0];
                            drive_low <= ~regs[pointer][7];
                            bit_cnt   <= 3'd0;
                            state     <= RD_DATA;
                        end else begin
                            drive_low <= 1'b0;
                            bit_cnt   <= 3'd0;
                            state     <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (first_byte) begin
                                pointer    <= rx_byte[3:0];
                                first_byte <= 1'b0;
                            end else begin
                                regs[pointer] <= rx_byte;
                                pointer       <= pointer + 4'd1;
                            end
                            state <= WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!drive_low) begin
                            drive_low <= 1'b1;
                        end else begin
                            drive_low <= 1'b0;
                            state     <= WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    // Master samples on rising edges; next bit goes out on falling edges
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            pointer <= pointer + 4'd1;
                            state   <= RD_ACK;
                        end
                    end else if (scl_fall) begin
                        tx        <= {tx[5:0], 1'b0};
                        drive_low <= ~tx[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_p1) state <= IGNORE;
                        else        master_ack <= 1'b1;
                    end else if (scl_fall) begin
                        if (master_ack) begin
                            tx         <= regs[pointer][6:0];
                            drive_low  <= ~regs[pointer][7];
                            master_ack <= 1'b0;
                            bit_cnt    <= 3'd0;
                            state      <= RD_DATA;
                        end else begin
                            drive_low <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    drive_low <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master on an open-drain bus.
module tb_i2c_slave;

    localparam int Q = 100;   // quarter of an I2C bit period

    logic clock;
    logic reset_n;
    logic m_scl;
    logic m_sda_low;
    wire  sda;

    int checks = 0;
    int errors = 0;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.SLAVE_ADDR(7'h7E)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .scl    (m_scl),
        .sda    (sda)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; #(Q);
        m_scl = 1'b1;     #(Q);
        m_sda_low = 1'b1; #(Q);
        m_scl = 1'b0;     #(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #(Q);
        m_scl = 1'b1;     #(Q);
        m_sda_low = 1'b0; #(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; #(Q);
        m_scl = 1'b1;   #(2*Q);
        m_scl = 1'b0;   #(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; #(Q);
        m_scl = 1'b1;     #(Q);
        b = sda;          #(Q);
        m_scl = 1'b0;     #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] v;

        // Reset pulsed low/high/low/high with master holding sda low, scl high
        reset_n = 1'b0; m_scl = 1'b1; m_sda_low = 1'b1;
        @(negedge clock);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        m_sda_low = 1'b0; #(Q);
        check_eq("stop_idle_sda", {7'd0, sda}, 8'h01);
        #(2*Q);
        check_eq("stop_idle_sda_late", {7'd0, sda}, 8'h01);
        // Clocking a matching address with no START must not be acknowledged
        m_scl = 1'b0; #(Q);
        write_byte(8'hFC, ack);
        check_eq("no_start_no_ack", {7'd0, ack}, 8'h01);

        // Own address + write is acknowledged and released afterwards
        i2c_start();
        write_byte(8'hFC, ack);
        check_eq("addr_ack", {7'd0, ack}, 8'h00);
        check_eq("addr_ack_release", {7'd0, sda}, 8'h01);
        i2c_stop();

        // Foreign address: no ACK, following bytes ignored
        i2c_start();
        write_byte(8'hA0, ack);
        check_eq("foreign_addr_nack", {7'd0, ack}, 8'h01);
        write_byte(8'h00, ack);
        check_eq("foreign_byte_nack", {7'd0, ack}, 8'h01);
        i2c_stop();

        // Pointer 15, write A5 and 3C with wrap to 0
        i2c_start();
        write_byte(8'hFC, ack); check_eq("wr_addr_ack", {7'd0, ack}, 8'h00);
        write_byte(8'h0F, ack); check_eq("wr_ptr_ack",  {7'd0, ack}, 8'h00);
        write_byte(8'hA5, ack); check_eq("wr_a5_ack",   {7'd0, ack}, 8'h00);
        write_byte(8'h3C, ack); check_eq("wr_3c_ack",   {7'd0, ack}, 8'h00);
        i2c_stop();

        // Set pointer 15, repeated START, read A5 (ACK) then 3C (NACK)
        i2c_start();
        write_byte(8'hFC, ack); check_eq("rd_waddr_ack", {7'd0, ack}, 8'h00);
        write_byte(8'h0F, ack); check_eq("rd_ptr_ack",   {7'd0, ack}, 8'h00);
        i2c_start();
        write_byte(8'hFD, ack); check_eq("rd_raddr_ack", {7'd0, ack}, 8'h00);
        read_byte(d, 1'b0);     check_eq("rd_reg15", d, 8'hA5);
        read_byte(d, 1'b1);     check_eq("rd_reg0",  d, 8'h3C);
        check_eq("rd_nack_release", {7'd0, sda}, 8'h01);
        i2c_stop();

        // Pointer set in one transaction persists into the next read
        i2c_start();
        write_byte(8'hFC, ack);
        write_byte(8'h0E, ack);
        write_byte(8'h11, ack); check_eq("wr_reg14_ack", {7'd0, ack}, 8'h00);
        i2c_stop();
        i2c_start();
        write_byte(8'hFD, ack);
        read_byte(d, 1'b0);     check_eq("persist_reg15", d, 8'hA5);
        read_byte(d, 1'b1);     check_eq("persist_reg0",  d, 8'h3C);
        i2c_stop();

        // Repeated START mid-byte aborts the write to reg2
        i2c_start();
        write_byte(8'hFC, ack);
        write_byte(8'h02, ack);
        v = 8'hEE;
        for (int i = 7; i >= 4; i--) write_bit(v[i]);
        i2c_start();
        write_byte(8'hFD, ack); check_eq("abort_raddr_ack", {7'd0, ack}, 8'h00);
        read_byte(d, 1'b1);     check_eq("abort_reg2", d, 8'h00);
        i2c_stop();

        // Reset during the 4th data bit of a write of 5A to reg1
        i2c_start();
        write_byte(8'hFC, ack);
        write_byte(8'h01, ack);
        v = 8'h5A;
        for (int i = 7; i >= 5; i--) write_bit(v[i]);
        m_sda_low = ~v[4]; #(Q);
        m_scl = 1'b1;      #(Q);
        reset_n = 1'b0;    #50;
        reset_n = 1'b1;    #50;
        m_scl = 1'b0;      #(Q);
        check_eq("rst_sda_released", {7'd0, sda}, 8'h01);
        for (int i = 3; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
        check_eq("rst_no_ack", {7'd0, ack}, 8'h01);
        i2c_stop();
        i2c_start();
        write_byte(8'hFC, ack); check_eq("rst_addr_ack", {7'd0, ack}, 8'h00);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'hFD, ack);
        read_byte(d, 1'b0);     check_eq("rst_reg0", d, 8'h00);
        read_byte(d, 1'b1);     check_eq("rst_reg1", d, 8'h00);
        i2c_stop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
